mips_control: RTL and testbench
===============================

// Module: mips_control
// PURPOSE
//  Multicycle MIPS control unit: Moore FSM plus ALU decoder sequencing the 32-bit multicycle datapath.
//  Decodes instruction[31:26]/[5:0], drives every datapath select/enable, and forms PCEn from ALUZero.
//  Stalls on a memory-ready handshake. Traps on illegal opcode/funct and on signed add/sub overflow.
// PARAMETERS
//  none (state codes and ALUControl codes live in mips_defs.vh)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   reset, synchronous, active-low
//  instruction  in   32  instruction register contents from the datapath
//  ALUZero      in   1   ALU zero flag, combinational
//  ALUOverflow  in   1   ALU signed overflow, combinational
//  memReady     in   1   memory completes the current read or write this cycle
//  PCEn         out  1   PC write enable = PCWrite | (Branch&ALUZero) | (BranchNe&~ALUZero)
//  Branch, BranchNe  out  1  beq / bne branch cycle
//  PCSource     out  2   00 ALUResult, 01 ALUOut, 10 jump target
//  ALUSrcA      out  1   0 PC, 1 A
//  ALUSrcB      out  2   00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
//  ALUControl   out  4   0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
//  IorD, MemRead, MemWrite, MemToReg, IRWrite, RegWrite, RegDst  out  1  datapath controls
//  trap         out  1   sticky; the FSM is in TRAP
//  state        out  4   current state code, for debug
// BEHAVIOUR
//  Reset (rst==0 at a clk edge): state<=FETCH, trap<=0.
//   While rst==0, all control outputs are forced to 0 combinationally; state reads FETCH after the edge.
//   Reset mid-instruction abandons it; no write is issued during the reset cycles.
//  Outputs are a Moore decode of state. Exception: IRWrite and PCWrite are qualified by memReady.
//  Unlisted outputs are 0 in every state.
//  FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ADD, PCSource=00.
//   IRWrite and PCWrite assert only when memReady=1. Stay in FETCH while memReady=0, else go to DECODE.
//  DECODE: ALUSrcA=0, ALUSrcB=11, ADD (branch target into ALUOut). Next state by opcode:
//   lw 23h / sw 2Bh -> MEMADR
//   R-type 00h -> EXEC (unknown funct -> TRAP)
//   beq 04h / bne 05h -> BRANCH
//   addi 08h / addiu 09h -> ADDIEX
//   j 02h -> JUMP
//   other -> TRAP
//  MEMADR: ALUSrcA=1, ALUSrcB=10, ADD. Next: MEMRD for lw, MEMWR for sw.
//  MEMRD: IorD=1, MemRead=1. Hold until memReady, then MEMWB.
//  MEMWB: RegDst=0, MemToReg=1, RegWrite=1. Next: FETCH.
//  MEMWR: IorD=1, MemWrite=1. Hold until memReady, then FETCH.
//  EXEC: ALUSrcA=1, ALUSrcB=00, ALUControl from funct:
//   20h/21h ADD, 22h/23h SUB, 24h AND, 25h OR, 27h NOR, 2Ah SLT.
//   add (20h) or sub (22h) with ALUOverflow=1 -> TRAP (no RegWrite); otherwise -> ALUWB.
//  ALUWB: RegDst=1, MemToReg=0, RegWrite=1. Next: FETCH.
//  ADDIEX: ALUSrcA=1, ALUSrcB=10, ADD. addi with ALUOverflow=1 -> TRAP; otherwise -> ADDIWB.
//  ADDIWB: RegDst=0, MemToReg=0, RegWrite=1. Next: FETCH.
//  BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSource=01. Branch=1 for beq, BranchNe=1 for bne. Next: FETCH.
//  JUMP: PCSource=10, PCWrite=1. Next: FETCH.
//  TRAP: all controls 0, trap=1. Terminal until reset.
//  Cycles per instruction with memReady tied to 1: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3.
//   Each memReady=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
//  memReady outside FETCH/MEMRD/MEMWR is ignored. ALUOverflow outside EXEC/ADDIEX is ignored.
// STRUCTURE
//  mips_defs.vh (shared include): state codes S_FETCH..S_TRAP, opcode and funct constants, ALUControl codes.
//  Sub-module alu_decoder (combinational): aluOp[1:0] + funct -> ALUControl plus illegal-funct flag.
//  Top level: state register, next-state logic, output decode, PCEn gating.
// TESTING
//  1. rst=0 for 2 cycles with memReady=1 -> all outputs 0 and trap=0; 1st cycle after release: FETCH, MemRead=1, IRWrite=1, PCEn=1.
//  2. lw (8C820004), memReady=1 -> state sequence FETCH,DECODE,MEMADR,MEMRD,MEMWB; RegWrite=1 with MemToReg=1 in cycle 5.
//  3. FETCH with memReady held 0 for 3 cycles -> IRWrite=0, PCEn=0, state FETCH; advance on the 4th cycle.
//  4. beq (10220003): ALUZero=1 in BRANCH -> PCEn=1, PCSource=01; same with ALUZero=0 -> PCEn=0. bne gives the inverse.
//  5. add (00221820) with ALUOverflow=1 in EXEC -> TRAP, RegWrite never asserted, trap=1 until rst=0; addu (00221821) same stimulus -> ALUWB.
//  6. opcode 3Fh, or R-type funct 3Fh -> TRAP right after DECODE; rst=0 then returns FETCH and clears trap.

Source files
------------

// File: rtl/mips_control_pkg.sv
// Shared constants and types for the multicycle MIPS control unit:
// state codes, opcode/funct values, ALU control codes and the control bundle.
package mips_control_pkg;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_ADDIEX = 4'd8;
    localparam logic [3:0] S_ADDIWB = 4'd9;
    localparam logic [3:0] S_BRANCH = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_TRAP   = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_t;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       branch_ne;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       alu_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
    } ctrl_t;

    // Only the trapping (signed) add/sub report overflow; the unsigned forms wrap.
    function automatic logic funct_traps_on_ovf(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB);
    endfunction

endpackage

// File: rtl/mips_control_if.sv
// Control-unit <-> datapath bundle: instruction/status in, select/enable strobes out.
interface mips_control_if;
    logic [31:0] instruction;
    logic        ALUZero;
    logic        ALUOverflow;
    logic        memReady;
    logic        PCEn;
    logic        Branch;
    logic        BranchNe;
    logic [1:0]  PCSource;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [3:0]  ALUControl;
    logic        IorD;
    logic        MemRead;
    logic        MemWrite;
    logic        MemToReg;
    logic        IRWrite;
    logic        RegWrite;
    logic        RegDst;
    logic        trap;
    logic [3:0]  state;

    modport master (
        input  instruction, ALUZero, ALUOverflow, memReady,
        output PCEn, Branch, BranchNe, PCSource, ALUSrcA, ALUSrcB, ALUControl,
               IorD, MemRead, MemWrite, MemToReg, IRWrite, RegWrite, RegDst, trap, state
    );

    modport slave (
        output instruction, ALUZero, ALUOverflow, memReady,
        input  PCEn, Branch, BranchNe, PCSource, ALUSrcA, ALUSrcB, ALUControl,
               IorD, MemRead, MemWrite, MemToReg, IRWrite, RegWrite, RegDst, trap, state
    );
endinterface

// File: rtl/mips_control_alu_decoder.sv
// Combinational ALU decoder: aluOp plus funct field to ALUControl, with an
// illegal-funct flag that depends on funct alone so DECODE can test it early.
module mips_control_alu_decoder
    import mips_control_pkg::*;
(
    input  aluop_t     alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       funct_illegal
);

    logic [3:0] funct_code_s;

    // R-type funct field to ALU operation
    always_comb begin
        funct_code_s  = ALU_AND;
        funct_illegal = 1'b0;
        case (funct)
            FN_ADD, FN_ADDU: funct_code_s = ALU_ADD;
            FN_SUB, FN_SUBU: funct_code_s = ALU_SUB;
            FN_AND:          funct_code_s = ALU_AND;
            FN_OR:           funct_code_s = ALU_OR;
            FN_NOR:          funct_code_s = ALU_NOR;
            FN_SLT:          funct_code_s = ALU_SLT;
            default: begin
                funct_code_s  = ALU_AND;
                funct_illegal = 1'b1;
            end
        endcase
    end

    // aluOp selects a fixed operation or defers to funct
    always_comb begin
        alu_control = ALU_AND;
        case (alu_op)
            ALUOP_ADD:   alu_control = ALU_ADD;
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: alu_control = funct_code_s;
            default:     alu_control = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mips_control.sv
// Multicycle MIPS control unit: Moore FSM sequencing the datapath, with
// memory-ready stalls and a terminal TRAP state for illegal code and overflow.
module mips_control
    import mips_control_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    mips_control_if.master bus
);

    logic [3:0] state_r;
    logic [3:0] next_state_s;
    logic       trap_r;
    logic [5:0] opcode_s;
    logic [5:0] funct_s;
    aluop_t     alu_op_s;
    logic [3:0] alu_control_s;
    logic       funct_illegal_s;
    ctrl_t      ctrl_s;
    ctrl_t      ctrl_out_s;

    assign opcode_s = bus.instruction[31:26];
    assign funct_s  = bus.instruction[5:0];

    mips_control_alu_decoder u_alu_dec (
        .alu_op        (alu_op_s),
        .funct         (funct_s),
        .alu_control   (alu_control_s),
        .funct_illegal (funct_illegal_s)
    );

    // State register; trap tracks residency in TRAP, which only reset leaves
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= S_FETCH;
            trap_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            trap_r  <= (next_state_s == S_TRAP);
        end
    end

    // Next-state logic; unknown state codes fall into TRAP
    always_comb begin
        next_state_s = S_TRAP;
        case (state_r)
            S_FETCH:  next_state_s = bus.memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode_s)
                    OP_LW, OP_SW:     next_state_s = S_MEMADR;
                    OP_RTYPE:         next_state_s = funct_illegal_s ? S_TRAP : S_EXEC;
                    OP_BEQ, OP_BNE:   next_state_s = S_BRANCH;
                    OP_ADDI, OP_ADDIU: next_state_s = S_ADDIEX;
                    OP_J:             next_state_s = S_JUMP;
                    default:          next_state_s = S_TRAP;
                endcase
            end
            S_MEMADR: next_state_s = (opcode_s == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  next_state_s = bus.memReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:  next_state_s = S_FETCH;
            S_MEMWR:  next_state_s = bus.memReady ? S_FETCH : S_MEMWR;
            S_EXEC: begin
                if (funct_traps_on_ovf(funct_s) && bus.ALUOverflow) begin
                    next_state_s = S_TRAP;
                end else begin
                    next_state_s = S_ALUWB;
                end
            end
            S_ALUWB:  next_state_s = S_FETCH;
            S_ADDIEX: begin
                if ((opcode_s == OP_ADDI) && bus.ALUOverflow) begin
                    next_state_s = S_TRAP;
                end else begin
                    next_state_s = S_ADDIWB;
                end
            end
            S_ADDIWB: next_state_s = S_FETCH;
            S_BRANCH: next_state_s = S_FETCH;
            S_JUMP:   next_state_s = S_FETCH;
            S_TRAP:   next_state_s = S_TRAP;
            default:  next_state_s = S_TRAP;
        endcase
    end

    // Moore output decode; only the FETCH strobes look at memReady
    always_comb begin
        ctrl_s   = '0;
        alu_op_s = ALUOP_ADD;
        case (state_r)
            S_FETCH: begin
                ctrl_s.mem_read  = 1'b1;
                ctrl_s.alu_src_b = 2'b01;
                ctrl_s.alu_en    = 1'b1;
                ctrl_s.ir_write  = bus.memReady;
                ctrl_s.pc_write  = bus.memReady;
            end
            S_DECODE: begin
                ctrl_s.alu_src_b = 2'b11;
                ctrl_s.alu_en    = 1'b1;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = 2'b10;
                ctrl_s.alu_en    = 1'b1;
            end
            S_MEMRD: begin
                ctrl_s.iord     = 1'b1;
                ctrl_s.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl_s.mem_to_reg = 1'b1;
                ctrl_s.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctrl_s.iord      = 1'b1;
                ctrl_s.mem_write = 1'b1;
            end
            S_EXEC: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_en    = 1'b1;
                alu_op_s         = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_s.reg_dst   = 1'b1;
                ctrl_s.reg_write = 1'b1;
            end
            S_ADDIWB: ctrl_s.reg_write = 1'b1;
            S_BRANCH: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_en    = 1'b1;
                ctrl_s.pc_source = 2'b01;
                ctrl_s.branch    = (opcode_s == OP_BEQ);
                ctrl_s.branch_ne = (opcode_s == OP_BNE);
                alu_op_s         = ALUOP_SUB;
            end
            S_JUMP: begin
                ctrl_s.pc_source = 2'b10;
                ctrl_s.pc_write  = 1'b1;
            end
            default: ctrl_s = '0;
        endcase
    end

    // Reset holds every strobe low so an abandoned instruction cannot write
    always_comb begin
        if (!rst) begin
            ctrl_out_s = '0;
        end else begin
            ctrl_out_s = ctrl_s;
        end
    end

    assign bus.PCEn       = ctrl_out_s.pc_write
                          | (ctrl_out_s.branch    &  bus.ALUZero)
                          | (ctrl_out_s.branch_ne & ~bus.ALUZero);
    assign bus.Branch     = ctrl_out_s.branch;
    assign bus.BranchNe   = ctrl_out_s.branch_ne;
    assign bus.PCSource   = ctrl_out_s.pc_source;
    assign bus.ALUSrcA    = ctrl_out_s.alu_src_a;
    assign bus.ALUSrcB    = ctrl_out_s.alu_src_b;
    assign bus.ALUControl = ctrl_out_s.alu_en ? alu_control_s : ALU_AND;
    assign bus.IorD       = ctrl_out_s.iord;
    assign bus.MemRead    = ctrl_out_s.mem_read;
    assign bus.MemWrite   = ctrl_out_s.mem_write;
    assign bus.MemToReg   = ctrl_out_s.mem_to_reg;
    assign bus.IRWrite    = ctrl_out_s.ir_write;
    assign bus.RegWrite   = ctrl_out_s.reg_write;
    assign bus.RegDst     = ctrl_out_s.reg_dst;
    assign bus.trap       = trap_r & rst;
    assign bus.state      = state_r;

endmodule

// File: tb/tb_mips_control.sv
// Self-checking bench for mips_control: per-cycle stimulus and expected output
// vectors are queued together, then replayed and compared one cycle at a time.
module tb_mips_control;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_control_if bus();

    mips_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Vector fields: state,trap,PCEn,Branch,BranchNe,PCSource,ALUSrcA,ALUSrcB,ALUControl,IorD,MemRead,MemWrite,MemToReg,IRWrite,RegWrite,RegDst
    localparam logic [23:0] X_RST   = 24'b0000_0_0_0_0_00_0_00_0000_0_0_0_0_0_0_0;
    localparam logic [23:0] X_FETCH = 24'b0000_0_1_0_0_00_0_01_0010_0_1_0_0_1_0_0;
    localparam logic [23:0] X_FWAIT = 24'b0000_0_0_0_0_00_0_01_0010_0_1_0_0_0_0_0;
    localparam logic [23:0] X_DEC   = 24'b0001_0_0_0_0_00_0_11_0010_0_0_0_0_0_0_0;
    localparam logic [23:0] X_MADR  = 24'b0010_0_0_0_0_00_1_10_0010_0_0_0_0_0_0_0;
    localparam logic [23:0] X_MRD   = 24'b0011_0_0_0_0_00_0_00_0000_1_1_0_0_0_0_0;
    localparam logic [23:0] X_MWB   = 24'b0100_0_0_0_0_00_0_00_0000_0_0_0_1_0_1_0;
    localparam logic [23:0] X_MWR   = 24'b0101_0_0_0_0_00_0_00_0000_1_0_1_0_0_0_0;
    localparam logic [23:0] X_EXADD = 24'b0110_0_0_0_0_00_1_00_0010_0_0_0_0_0_0_0;
    localparam logic [23:0] X_EXSUB = 24'b0110_0_0_0_0_00_1_00_0110_0_0_0_0_0_0_0;
    localparam logic [23:0] X_EXSLT = 24'b0110_0_0_0_0_00_1_00_0111_0_0_0_0_0_0_0;
    localparam logic [23:0] X_EXNOR = 24'b0110_0_0_0_0_00_1_00_1100_0_0_0_0_0_0_0;
    localparam logic [23:0] X_AWB   = 24'b0111_0_0_0_0_00_0_00_0000_0_0_0_0_0_1_1;
    localparam logic [23:0] X_AIEX  = 24'b1000_0_0_0_0_00_1_10_0010_0_0_0_0_0_0_0;
    localparam logic [23:0] X_AIWB  = 24'b1001_0_0_0_0_00_0_00_0000_0_0_0_0_0_1_0;
    localparam logic [23:0] X_BEQT  = 24'b1010_0_1_1_0_01_1_00_0110_0_0_0_0_0_0_0;
    localparam logic [23:0] X_BEQF  = 24'b1010_0_0_1_0_01_1_00_0110_0_0_0_0_0_0_0;
    localparam logic [23:0] X_BNET  = 24'b1010_0_1_0_1_01_1_00_0110_0_0_0_0_0_0_0;
    localparam logic [23:0] X_BNEF  = 24'b1010_0_0_0_1_01_1_00_0110_0_0_0_0_0_0_0;
    localparam logic [23:0] X_JMP   = 24'b1011_0_1_0_0_10_0_00_0000_0_0_0_0_0_0_0;
    localparam logic [23:0] X_TRAP  = 24'b1100_1_0_0_0_00_0_00_0000_0_0_0_0_0_0_0;
    localparam logic [23:0] M_ALL   = 24'hFFFFFF;
    localparam logic [23:0] M_CTL   = 24'h0FFFFF;

    localparam logic [31:0] I_LW    = 32'h8C820004;
    localparam logic [31:0] I_SW    = 32'hAC820004;
    localparam logic [31:0] I_BEQ   = 32'h10220003;
    localparam logic [31:0] I_BNE   = 32'h14220003;
    localparam logic [31:0] I_ADD   = 32'h00221820;
    localparam logic [31:0] I_ADDU  = 32'h00221821;
    localparam logic [31:0] I_SUB   = 32'h00221822;
    localparam logic [31:0] I_SLT   = 32'h0022182A;
    localparam logic [31:0] I_NOR   = 32'h00221827;
    localparam logic [31:0] I_ADDI  = 32'h20420005;
    localparam logic [31:0] I_ADDIU = 32'h24420005;
    localparam logic [31:0] I_J     = 32'h08000010;
    localparam logic [31:0] I_OP3F  = 32'hFC000000;
    localparam logic [31:0] I_FN3F  = 32'h0000003F;

    typedef struct {
        logic [31:0] instr;
        logic        rstv;
        logic        rdy;
        logic        zero;
        logic        ovf;
        logic [23:0] val;
        logic [23:0] mask;
        string       name;
    } item_t;

    item_t sb[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [23:0] obs();
        return {bus.state, bus.trap, bus.PCEn, bus.Branch, bus.BranchNe, bus.PCSource,
                bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.IorD, bus.MemRead,
                bus.MemWrite, bus.MemToReg, bus.IRWrite, bus.RegWrite, bus.RegDst};
    endfunction

    task automatic push(input logic [31:0] ins, input logic r, input logic rdy, input logic z,
                        input logic o, input logic [23:0] v, input logic [23:0] m, input string n);
        item_t e;
        e.instr = ins; e.rstv = r; e.rdy = rdy; e.zero = z; e.ovf = o;
        e.val = v; e.mask = m; e.name = n;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        item_t it;
        push(I_J, 1'b0, 1'b1, 1'b0, 1'b0, X_RST,   M_CTL, "reset_cyc1");
        push(I_J, 1'b0, 1'b1, 1'b0, 1'b0, X_RST,   M_ALL, "reset_cyc2");
        push(I_J, 1'b1, 1'b1, 1'b0, 1'b0, X_FETCH, M_ALL, "reset_first_fetch");
        push(I_J, 1'b1, 1'b1, 1'b0, 1'b0, X_DEC,   M_ALL, "j_decode");
        push(I_J, 1'b1, 1'b1, 1'b1, 1'b0, X_JMP,   M_ALL, "j_jump");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            @(negedge clk);
            rst = it.rstv; bus.instruction = it.instr; bus.memReady = it.rdy;
            bus.ALUZero = it.zero; bus.ALUOverflow = it.ovf;
            #1;
            checks++;
            if ((obs() & it.mask) !== (it.val & it.mask)) begin
                errors++;
                $display("FAIL %s: got %h expected %h", it.name, obs() & it.mask, it.val & it.mask);
            end
        end
    endtask

    task automatic test_lw();
        item_t it;
        push(I_LW, 1'b1, 1'b1, 1'b0, 1'b0, X_FETCH, M_ALL, "lw_fetch");
        push(I_LW, 1'b1, 1'b1, 1'b0, 1'b0, X_DEC,   M_ALL, "lw_decode");
        push(I_LW, 1'b1, 1'b1, 1'b0, 1'b1, X_MADR,  M_ALL, "lw_memadr");
        push(I_LW, 1'b1, 1'b0, 1'b0, 1'b0, X_MRD,   M_ALL, "lw_memrd_wait");
        push(I_LW, 1'b1, 1'b1, 1'b0, 1'b0, X_MRD,   M_ALL, "lw_memrd");
        push(I_LW, 1'b1, 1'b1, 1'b0, 1'b0, X_MWB,   M_ALL, "lw_memwb");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            @(negedge clk);
            rst = it.rstv; bus.instruction = it.instr; bus.memReady = it.rdy;
            bus.ALUZero = it.zero; bus.ALUOverflow = it.ovf;
            #1;
            checks++;
            if ((obs() & it.mask) !== (it.val & it.mask)) begin
                errors++;
                $display("FAIL %s: got %h expected %h", it.name, obs() & it.mask, it.val & it.mask);
            end
        end
    endtask

    task automatic test_fetch_stall();
        item_t it;
        for (int i = 0; i < 3; i++) push(I_SW, 1'b1, 1'b0, 1'b0, 1'b0, X_FWAIT, M_ALL, "fetch_stall");
        push(I_SW, 1'b1, 1'b1, 1'b0, 1'b0, X_FETCH, M_ALL, "sw_fetch");
        push(I_SW, 1'b1, 1'b0, 1'b0, 1'b0, X_DEC,   M_ALL, "sw_decode_noready");
        push(I_SW, 1'b1, 1'b1, 1'b0, 1'b0, X_MADR,  M_ALL, "sw_memadr");
        push(I_SW, 1'b1, 1'b0, 1'b0, 1'b0, X_MWR,   M_ALL, "sw_memwr_wait");
        push(I_SW, 1'b1, 1'b1, 1'b0, 1'b0, X_MWR,   M_ALL, "sw_memwr");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            @(negedge clk);
            rst = it.rstv; bus.instruction = it.instr; bus.memReady = it.rdy;
            bus.ALUZero = it.zero; bus.ALUOverflow = it.ovf;
            #1;
            checks++;
            if ((obs() & it.mask) !== (it.val & it.mask)) begin
                errors++;
                $display("FAIL %s: got %h expected %h", it.name, obs() & it.mask, it.val & it.mask);
            end
        end
    endtask

    task automatic test_branch();
        item_t it;
        push(I_BEQ, 1'b1, 1'b1, 1'b0, 1'b0, X_FETCH, M_ALL, "beq_fetch");
        push(I_BEQ, 1'b1, 1'b1, 1'b0, 1'b0, X_DEC,   M_ALL, "beq_decode");
        push(I_BEQ, 1'b1, 1'b1, 1'b1, 1'b1, X_BEQT,  M_ALL, "beq_taken");
        push(I_BEQ, 1'b1, 1'b1, 1'b0, 1'b0, X_FETCH, M_ALL, "beq_fetch2");
        push(I_BEQ, 1'b1, 1'b1, 1'b0, 1'b0, X_DEC,   M_ALL, "beq_decode2");
        push(I_BEQ, 1'b1, 1'b1, 1'b0, 1'b0, X_BEQF,  M_ALL, "beq_not_taken");
        push(I_BNE, 1'b1, 1'b1, 1'b0, 1'b0, X_FETCH, M_ALL, "bne_fetch");
        push(I_BNE, 1'b1, 1'b1, 1'b0, 1'b0, X_DEC,   M_ALL, "bne_decode");
        push(I_BNE, 1'b1, 1'b1, 1'b0, 1'b0, X_BNET,  M_ALL, "bne_taken");
        push(I_BNE, 1'b1, 1'b1, 1'b0, 1'b0, X_FETCH, M_ALL, "bne_fetch2");
        push(I_BNE, 1'b1, 1'b1, 1'b0, 1'b0, X_DEC,   M_ALL, "bne_decode2");
        push(I_BNE, 1'b1, 1'b0, 1'b1, 1'b0, X_BNEF,  M_ALL, "bne_not_taken");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            @(negedge clk);
            rst = it.rstv; bus.instruction = it.instr; bus.memReady = it.rdy;
            bus.ALUZero = it.zero; bus.ALUOverflow = it.ovf;
            #1;
            checks++;
            if ((obs() & it.mask) !== (it.val & it.mask)) begin
                errors++;
                $display("FAIL %s: got %h expected %h", it.name, obs() & it.mask, it.val & it.mask);
            end
        end
    endtask

    task automatic test_overflow();
        item_t it;
        push(I_ADD,  1'b1, 1'b1, 1'b0, 1'b0, X_FETCH, M_ALL, "add_fetch");
        push(I_ADD,  1'b1, 1'b1, 1'b0, 1'b0, X_DEC,   M_ALL, "add_decode");
        push(I_ADD,  1'b1, 1'b1, 1'b0, 1'b1, X_EXADD, M_ALL, "add_exec_ovf");
        push(I_ADD,  1'b1, 1'b1, 1'b0, 1'b0, X_TRAP,  M_ALL, "add_trap");
        push(I_ADD,  1'b1, 1'b1, 1'b1, 1'b1, X_TRAP,  M_ALL, "add_trap_sticky");
        push(I_ADD,  1'b0, 1'b1, 1'b0, 1'b0, X_RST,   M_CTL, "add_trap_reset");
        push(I_ADDU, 1'b1, 1'b1, 1'b0, 1'b0, X_FETCH, M_ALL, "addu_fetch");
        push(I_ADDU, 1'b1, 1'b1, 1'b0, 1'b0, X_DEC,   M_ALL, "addu_decode");
        push(I_ADDU, 1'b1, 1'b1, 1'b0, 1'b1, X_EXADD, M_ALL, "addu_exec_ovf");
        push(I_ADDU, 1'b1, 1'b1, 1'b0, 1'b0, X_AWB,   M_ALL, "addu_aluwb");
        push(I_SUB,  1'b1, 1'b1, 1'b0, 1'b0, X_FETCH, M_ALL, "sub_fetch");
        push(I_SUB,  1'b1, 1'b1, 1'b0, 1'b0, X_DEC,   M_ALL, "sub_decode");
        push(I_SUB,  1'b1, 1'b1, 1'b0, 1'b1, X_EXSUB, M_ALL, "sub_exec_ovf");
        push(I_SUB,  1'b1, 1'b1, 1'b0, 1'b0, X_TRAP,  M_ALL, "sub_trap");
        push(I_SUB,  1'b0, 1'b1, 1'b0, 1'b0, X_RST,   M_CTL, "sub_trap_reset");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            @(negedge clk);
            rst = it.rstv; bus.instruction = it.instr; bus.memReady = it.rdy;
            bus.ALUZero = it.zero; bus.ALUOverflow = it.ovf;
            #1;
            checks++;
            if ((obs() & it.mask) !== (it.val & it.mask)) begin
                errors++;
                $display("FAIL %s: got %h expected %h", it.name, obs() & it.mask, it.val & it.mask);
            end
        end
    endtask

    task automatic test_illegal();
        item_t it;
        push(I_OP3F, 1'b1, 1'b1, 1'b0, 1'b0, X_FETCH, M_ALL, "op3f_fetch");
        push(I_OP3F, 1'b1, 1'b1, 1'b0, 1'b0, X_DEC,   M_ALL, "op3f_decode");
        push(I_OP3F, 1'b1, 1'b1, 1'b0, 1'b0, X_TRAP,  M_ALL, "op3f_trap");
        push(I_OP3F, 1'b0, 1'b1, 1'b0, 1'b0, X_RST,   M_CTL, "op3f_reset");
        push(I_FN3F, 1'b1, 1'b1, 1'b0, 1'b0, X_FETCH, M_ALL, "fn3f_fetch");
        push(I_FN3F, 1'b1, 1'b1, 1'b0, 1'b0, X_DEC,   M_ALL, "fn3f_decode");
        push(I_FN3F, 1'b1, 1'b1, 1'b0, 1'b0, X_TRAP,  M_ALL, "fn3f_trap");
        push(I_FN3F, 1'b1, 1'b0, 1'b1, 1'b1, X_TRAP,  M_ALL, "fn3f_trap_hold");
        push(I_FN3F, 1'b0, 1'b1, 1'b0, 1'b0, X_RST,   M_CTL, "fn3f_reset");
        push(I_SW,   1'b1, 1'b1, 1'b0, 1'b0, X_FETCH, M_ALL, "abort_fetch");
        push(I_SW,   1'b1, 1'b1, 1'b0, 1'b0, X_DEC,   M_ALL, "abort_decode");
        push(I_SW,   1'b1, 1'b1, 1'b0, 1'b0, X_MADR,  M_ALL, "abort_memadr");
        push(I_SW,   1'b0, 1'b1, 1'b0, 1'b0, X_RST,   M_CTL, "abort_memwr_reset");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            @(negedge clk);
            rst = it.rstv; bus.instruction = it.instr; bus.memReady = it.rdy;
            bus.ALUZero = it.zero; bus.ALUOverflow = it.ovf;
            #1;
            checks++;
            if ((obs() & it.mask) !== (it.val & it.mask)) begin
                errors++;
                $display("FAIL %s: got %h expected %h", it.name, obs() & it.mask, it.val & it.mask);
            end
        end
    endtask

    task automatic test_back_to_back();
        item_t it;
        push(I_SLT,   1'b1, 1'b1, 1'b0, 1'b0, X_FETCH, M_ALL, "slt_fetch");
        push(I_SLT,   1'b1, 1'b1, 1'b0, 1'b0, X_DEC,   M_ALL, "slt_decode");
        push(I_SLT,   1'b1, 1'b1, 1'b0, 1'b1, X_EXSLT, M_ALL, "slt_exec");
        push(I_SLT,   1'b1, 1'b1, 1'b0, 1'b0, X_AWB,   M_ALL, "slt_aluwb");
        push(I_NOR,   1'b1, 1'b1, 1'b0, 1'b0, X_FETCH, M_ALL, "nor_fetch");
        push(I_NOR,   1'b1, 1'b1, 1'b0, 1'b0, X_DEC,   M_ALL, "nor_decode");
        push(I_NOR,   1'b1, 1'b1, 1'b0, 1'b0, X_EXNOR, M_ALL, "nor_exec");
        push(I_NOR,   1'b1, 1'b1, 1'b0, 1'b0, X_AWB,   M_ALL, "nor_aluwb");
        push(I_ADDI,  1'b1, 1'b1, 1'b0, 1'b0, X_FETCH, M_ALL, "addi_fetch");
        push(I_ADDI,  1'b1, 1'b1, 1'b0, 1'b0, X_DEC,   M_ALL, "addi_decode");
        push(I_ADDI,  1'b1, 1'b1, 1'b0, 1'b0, X_AIEX,  M_ALL, "addi_exec");
        push(I_ADDI,  1'b1, 1'b1, 1'b0, 1'b0, X_AIWB,  M_ALL, "addi_wb");
        push(I_ADDIU, 1'b1, 1'b1, 1'b0, 1'b0, X_FETCH, M_ALL, "addiu_fetch");
        push(I_ADDIU, 1'b1, 1'b1, 1'b0, 1'b0, X_DEC,   M_ALL, "addiu_decode");
        push(I_ADDIU, 1'b1, 1'b1, 1'b0, 1'b1, X_AIEX,  M_ALL, "addiu_exec_ovf");
        push(I_ADDIU, 1'b1, 1'b1, 1'b0, 1'b0, X_AIWB,  M_ALL, "addiu_wb");
        push(I_ADDI,  1'b1, 1'b1, 1'b0, 1'b0, X_FETCH, M_ALL, "addi2_fetch");
        push(I_ADDI,  1'b1, 1'b1, 1'b0, 1'b0, X_DEC,   M_ALL, "addi2_decode");
        push(I_ADDI,  1'b1, 1'b1, 1'b0, 1'b1, X_AIEX,  M_ALL, "addi2_exec_ovf");
        push(I_ADDI,  1'b1, 1'b1, 1'b0, 1'b0, X_TRAP,  M_ALL, "addi2_trap");
        push(I_ADDI,  1'b0, 1'b1, 1'b0, 1'b0, X_RST,   M_CTL, "addi2_reset");
        push(I_J,     1'b1, 1'b1, 1'b0, 1'b0, X_FETCH, M_ALL, "j2_fetch");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            @(negedge clk);
            rst = it.rstv; bus.instruction = it.instr; bus.memReady = it.rdy;
            bus.ALUZero = it.zero; bus.ALUOverflow = it.ovf;
            #1;
            checks++;
            if ((obs() & it.mask) !== (it.val & it.mask)) begin
                errors++;
                $display("FAIL %s: got %h expected %h", it.name, obs() & it.mask, it.val & it.mask);
            end
        end
    endtask

    initial begin
        rst             = 1'b0;
        bus.instruction = 32'h0000_0000;
        bus.memReady    = 1'b1;
        bus.ALUZero     = 1'b0;
        bus.ALUOverflow = 1'b0;
        test_reset();
        test_lw();
        test_fetch_stall();
        test_branch();
        test_overflow();
        test_illegal();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
